// File: rtl/reg_access_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : reg_access_arbiter
// Purpose  : Two-requester arbiter/sequencer for a single-port register file.
//            Build option: REG_ARB_FIXED_PRIO_EN (A always wins a tie).
// Revision : 1.0 - initial release
// ============================================================================
module reg_access_arbiter #(
    parameter int WORD_SIZE = 16,
    parameter int ADDR_SIZE = 2
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 REQ_A,
    input  logic                 WE_A,
    input  logic [ADDR_SIZE-1:0] ADDR_A,
    input  logic [WORD_SIZE-1:0] WDATA_A,
    output logic                 ACK_A,
    output logic [WORD_SIZE-1:0] RDATA_A,
    input  logic                 REQ_B,
    input  logic                 WE_B,
    input  logic [ADDR_SIZE-1:0] ADDR_B,
    input  logic [WORD_SIZE-1:0] WDATA_B,
    output logic                 ACK_B,
    output logic [WORD_SIZE-1:0] RDATA_B,
    output logic                 BUSY,
    output logic                 REG_W,
    output logic                 REG_ON,
    output logic [ADDR_SIZE-1:0] REG_ADDR,
    output logic [WORD_SIZE-1:0] REG_DIN,
    input  logic [WORD_SIZE-1:0] REG_DOUT
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_ACK    = 2'd2
    } state_t;

    localparam logic c_GNT_A = 1'b0;
    localparam logic c_GNT_B = 1'b1;

    state_t                 r_state_q,   w_state_d;
    logic                   r_grant_q,   w_grant_d;
    logic                   r_reg_w_q,   w_reg_w_d;
    logic                   r_reg_on_q,  w_reg_on_d;
    logic [ADDR_SIZE-1:0]   r_reg_addr_q, w_reg_addr_d;
    logic [WORD_SIZE-1:0]   r_reg_din_q, w_reg_din_d;
    logic                   r_ack_a_q,   w_ack_a_d;
    logic                   r_ack_b_q,   w_ack_b_d;
    logic [WORD_SIZE-1:0]   r_rdata_a_q, w_rdata_a_d;
    logic [WORD_SIZE-1:0]   r_rdata_b_q, w_rdata_b_d;
    logic                   w_pick_b;

`ifdef REG_ARB_FIXED_PRIO_EN
    always_comb begin
        w_pick_b = REQ_B && !REQ_A;
    end
`else
    logic r_last_grant_q, w_last_grant_d;

    // On a tie, grant whichever requester was not served last.
    always_comb begin
        w_pick_b = REQ_B && (!REQ_A || (r_last_grant_q == c_GNT_A));
    end

    always_comb begin
        w_last_grant_d = r_last_grant_q;
        if ((r_state_q == ST_IDLE) && (REQ_A || REQ_B)) begin
            w_last_grant_d = w_pick_b;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_last_grant_q <= c_GNT_B;
        end else begin
            r_last_grant_q <= w_last_grant_d;
        end
    end
`endif

    always_comb begin
        w_state_d    = r_state_q;
        w_grant_d    = r_grant_q;
        w_reg_w_d    = r_reg_w_q;
        w_reg_on_d   = r_reg_on_q;
        w_reg_addr_d = r_reg_addr_q;
        w_reg_din_d  = r_reg_din_q;
        w_ack_a_d    = 1'b0;
        w_ack_b_d    = 1'b0;
        w_rdata_a_d  = r_rdata_a_q;
        w_rdata_b_d  = r_rdata_b_q;
        case (r_state_q)
            ST_IDLE: begin
                if (REQ_A || REQ_B) begin
                    w_state_d    = ST_ACCESS;
                    w_grant_d    = w_pick_b;
                    w_reg_on_d   = 1'b1;
                    w_reg_w_d    = w_pick_b ? WE_B    : WE_A;
                    w_reg_addr_d = w_pick_b ? ADDR_B  : ADDR_A;
                    w_reg_din_d  = w_pick_b ? WDATA_B : WDATA_A;
                end
            end
            ST_ACCESS: begin
                // REG_DOUT is only looked at here, during a read access.
                w_state_d  = ST_ACK;
                w_reg_on_d = 1'b0;
                w_reg_w_d  = 1'b0;
                if (r_grant_q == c_GNT_B) begin
                    w_ack_b_d = 1'b1;
                    if (!r_reg_w_q) w_rdata_b_d = REG_DOUT;
                end else begin
                    w_ack_a_d = 1'b1;
                    if (!r_reg_w_q) w_rdata_a_d = REG_DOUT;
                end
            end
            ST_ACK: begin
                w_state_d = ST_IDLE;
            end
            default: begin
                w_state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state_q    <= ST_IDLE;
            r_grant_q    <= c_GNT_A;
            r_reg_w_q    <= 1'b0;
            r_reg_on_q   <= 1'b0;
            r_reg_addr_q <= '0;
            r_reg_din_q  <= '0;
            r_ack_a_q    <= 1'b0;
            r_ack_b_q    <= 1'b0;
            r_rdata_a_q  <= '0;
            r_rdata_b_q  <= '0;
        end else begin
            r_state_q    <= w_state_d;
            r_grant_q    <= w_grant_d;
            r_reg_w_q    <= w_reg_w_d;
            r_reg_on_q   <= w_reg_on_d;
            r_reg_addr_q <= w_reg_addr_d;
            r_reg_din_q  <= w_reg_din_d;
            r_ack_a_q    <= w_ack_a_d;
            r_ack_b_q    <= w_ack_b_d;
            r_rdata_a_q  <= w_rdata_a_d;
            r_rdata_b_q  <= w_rdata_b_d;
        end
    end

    assign ACK_A    = r_ack_a_q;
    assign ACK_B    = r_ack_b_q;
    assign RDATA_A  = r_rdata_a_q;
    assign RDATA_B  = r_rdata_b_q;
    assign BUSY     = (r_state_q != ST_IDLE);
    assign REG_W    = r_reg_w_q;
    assign REG_ON   = r_reg_on_q;
    assign REG_ADDR = r_reg_addr_q;
    assign REG_DIN  = r_reg_din_q;

endmodule
`default_nettype wire

// File: tb/tb_reg_access_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_access_arbiter
// Purpose  : Directed self-checking bench for reg_access_arbiter with a
//            behavioural tristate register-file model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_access_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_a, we_a, req_b, we_b;
    logic [1:0]  addr_a, addr_b;
    logic [15:0] wdata_a, wdata_b;
    logic        ack_a, ack_b, busy, reg_w, reg_on;
    logic [15:0] rdata_a, rdata_b, reg_din;
    logic [1:0]  reg_addr;
    wire  [15:0] reg_dout;
    logic        dout_x_mode = 1'b0;

    int checks = 0;
    int errors = 0;

    logic [15:0] mem [4] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};

    always #5 clk = ~clk;

    always @(posedge clk) if (reg_w && reg_on) mem[reg_addr] <= reg_din;
    assign reg_dout = (reg_on && !reg_w) ? mem[reg_addr] : (dout_x_mode ? 16'hxxxx : 16'hzzzz);

    reg_access_arbiter #(.WORD_SIZE(16), .ADDR_SIZE(2)) dut (
        .CLK(clk), .RST(rst),
        .REQ_A(req_a), .WE_A(we_a), .ADDR_A(addr_a), .WDATA_A(wdata_a),
        .ACK_A(ack_a), .RDATA_A(rdata_a),
        .REQ_B(req_b), .WE_B(we_b), .ADDR_B(addr_b), .WDATA_B(wdata_b),
        .ACK_B(ack_b), .RDATA_B(rdata_b),
        .BUSY(busy), .REG_W(reg_w), .REG_ON(reg_on), .REG_ADDR(reg_addr),
        .REG_DIN(reg_din), .REG_DOUT(reg_dout)
    );

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        req_a = 0; we_a = 0; addr_a = 0; wdata_a = 0;
        req_b = 0; we_b = 0; addr_b = 0; wdata_b = 0;
    endtask

    task automatic pulse_reset();
        rst = 1; tick(); tick(); rst = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        for (int i = 0; i < 2; i++) begin
            req_a = 1'($urandom); we_a = 1'($urandom); addr_a = 2'($urandom); wdata_a = 16'($urandom);
            req_b = 1'($urandom); we_b = 1'($urandom); addr_b = 2'($urandom); wdata_b = 16'($urandom);
            tick();
            checks++;
            if ({ack_a, ack_b, busy, reg_w, reg_on, reg_addr, reg_din, rdata_a, rdata_b} !== 55'd0) begin
                errors++;
                $display("FAIL reset_outputs cycle %0d: got ack=%b%b busy=%b w=%b on=%b addr=%h din=%h ra=%h rb=%h, expected all 0",
                         i, ack_a, ack_b, busy, reg_w, reg_on, reg_addr, reg_din, rdata_a, rdata_b);
            end
        end
        rst = 0;
        idle_inputs();
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++;
            if ({ack_a, ack_b, busy} !== 3'b000) begin
                errors++;
                $display("FAIL post_reset_idle cycle %0d: got ack_a=%b ack_b=%b busy=%b, expected 000", i, ack_a, ack_b, busy);
            end
        end
    endtask

    task automatic test_write_read_a();
        req_a = 1; we_a = 1; addr_a = 2; wdata_a = 16'hBEEF;
        tick();
        checks++;
        if ({reg_w, reg_on, reg_addr, reg_din, busy, ack_a} !== {1'b1, 1'b1, 2'd2, 16'hBEEF, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL wr_access: got w=%b on=%b addr=%h din=%h busy=%b ack_a=%b, expected 1 1 2 beef 1 0",
                     reg_w, reg_on, reg_addr, reg_din, busy, ack_a);
        end
        tick();
        checks++;
        if ({ack_a, ack_b, reg_w, reg_on, rdata_a} !== {1'b1, 1'b0, 1'b0, 1'b0, 16'h0000}) begin
            errors++;
            $display("FAIL wr_ack: got ack_a=%b ack_b=%b w=%b on=%b rdata_a=%h, expected 1 0 0 0 0000",
                     ack_a, ack_b, reg_w, reg_on, rdata_a);
        end
        we_a = 0;
        tick();
        checks++;
        if ({busy, ack_a} !== 2'b00) begin
            errors++;
            $display("FAIL rd_idle_gap: got busy=%b ack_a=%b, expected 00", busy, ack_a);
        end
        tick();
        checks++;
        if ({reg_w, reg_on, reg_addr, ack_a} !== {1'b0, 1'b1, 2'd2, 1'b0}) begin
            errors++;
            $display("FAIL rd_access: got w=%b on=%b addr=%h ack_a=%b, expected 0 1 2 0", reg_w, reg_on, reg_addr, ack_a);
        end
        tick();
        checks++;
        if ({ack_a, rdata_a} !== {1'b1, 16'hBEEF}) begin
            errors++;
            $display("FAIL rd_after_wr: got ack_a=%b rdata_a=%h, expected 1 beef", ack_a, rdata_a);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_tie_from_reset();
        pulse_reset();
        req_a = 1; we_a = 0; addr_a = 1;
        req_b = 1; we_b = 1; addr_b = 1; wdata_b = 16'h1234;
        tick();
        checks++;
        if ({reg_w, reg_addr} !== {1'b0, 2'd1}) begin
            errors++;
            $display("FAIL tie_first_grant: got w=%b addr=%h, expected read of addr 1 (0 1)", reg_w, reg_addr);
        end
        tick();
        checks++;
        if ({ack_a, ack_b, rdata_a} !== {1'b1, 1'b0, 16'h2222}) begin
            errors++;
            $display("FAIL tie_a_old_data: got ack_a=%b ack_b=%b rdata_a=%h, expected 1 0 2222", ack_a, ack_b, rdata_a);
        end
        req_a = 0;
        tick();
        tick();
        checks++;
        if ({reg_w, reg_on, reg_din} !== {1'b1, 1'b1, 16'h1234}) begin
            errors++;
            $display("FAIL tie_b_access: got w=%b on=%b din=%h, expected 1 1 1234", reg_w, reg_on, reg_din);
        end
        tick();
        checks++;
        if ({ack_a, ack_b, rdata_b} !== {1'b0, 1'b1, 16'h0000}) begin
            errors++;
            $display("FAIL tie_b_ack: got ack_a=%b ack_b=%b rdata_b=%h, expected 0 1 0000", ack_a, ack_b, rdata_b);
        end
        req_b = 0; we_b = 0;
        req_a = 1;
        tick(); tick(); tick();
        checks++;
        if ({ack_a, rdata_a} !== {1'b1, 16'h1234}) begin
            errors++;
            $display("FAIL tie_a_reread: got ack_a=%b rdata_a=%h, expected 1 1234", ack_a, rdata_a);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_back_to_back();
        logic exp_a, exp_b;
        pulse_reset();
        req_a = 1; we_a = 0; addr_a = 0;
        req_b = 1; we_b = 0; addr_b = 3;
        for (int k = 1; k <= 12; k++) begin
            tick();
`ifdef REG_ARB_FIXED_PRIO_EN
            exp_a = (k % 3 == 2);
            exp_b = 1'b0;
`else
            exp_a = (k % 6 == 2);
            exp_b = (k % 6 == 5);
`endif
            checks++;
            if ({ack_a, ack_b} !== {exp_a, exp_b}) begin
                errors++;
                $display("FAIL b2b_acks cycle %0d: got ack_a=%b ack_b=%b, expected %b %b", k, ack_a, ack_b, exp_a, exp_b);
            end
        end
        checks++;
`ifdef REG_ARB_FIXED_PRIO_EN
        if ({rdata_a, rdata_b} !== {16'h1111, 16'h0000}) begin
            errors++;
            $display("FAIL b2b_rdata: got rdata_a=%h rdata_b=%h, expected 1111 0000", rdata_a, rdata_b);
        end
`else
        if ({rdata_a, rdata_b} !== {16'h1111, 16'h4444}) begin
            errors++;
            $display("FAIL b2b_rdata: got rdata_a=%h rdata_b=%h, expected 1111 4444", rdata_a, rdata_b);
        end
`endif
        idle_inputs();
        tick();
    endtask

    task automatic test_reset_during_write();
        pulse_reset();
        req_b = 1; we_b = 1; addr_b = 3; wdata_b = 16'h00FF;
        tick();
        checks++;
        if ({busy, reg_w, reg_on, reg_addr} !== {1'b1, 1'b1, 1'b1, 2'd3}) begin
            errors++;
            $display("FAIL rstwr_access: got busy=%b w=%b on=%b addr=%h, expected 1 1 1 3", busy, reg_w, reg_on, reg_addr);
        end
        rst = 1;
        idle_inputs();
        tick();
        checks++;
        if ({ack_b, busy, reg_on, reg_w} !== 4'b0000) begin
            errors++;
            $display("FAIL rstwr_no_ack: got ack_b=%b busy=%b on=%b w=%b, expected 0000", ack_b, busy, reg_on, reg_w);
        end
        rst = 0;
        tick();
        checks++;
        if ({ack_b, busy} !== 2'b00) begin
            errors++;
            $display("FAIL rstwr_idle: got ack_b=%b busy=%b, expected 00", ack_b, busy);
        end
        req_a = 1; we_a = 0; addr_a = 3;
        tick(); tick();
        checks++;
        if ({ack_a, rdata_a} !== {1'b1, 16'h00FF}) begin
            errors++;
            $display("FAIL rstwr_readback: got ack_a=%b rdata_a=%h, expected 1 00ff", ack_a, rdata_a);
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_dout_x();
        dout_x_mode = 1;
        req_b = 1; we_b = 1; addr_b = 0; wdata_b = 16'hA5A5;
        for (int k = 1; k <= 3; k++) begin
            tick();
            if (k == 2) req_b = 0;
            checks++;
            if ($isunknown({rdata_a, rdata_b}) || {rdata_a, rdata_b} !== {16'h00FF, 16'h0000}) begin
                errors++;
                $display("FAIL xbus_write cycle %0d: got rdata_a=%h rdata_b=%h, expected 00ff 0000", k, rdata_a, rdata_b);
            end
        end
        req_b = 1; we_b = 0; addr_b = 0;
        tick(); tick();
        checks++;
        if ({ack_b, rdata_b, rdata_a} !== {1'b1, 16'hA5A5, 16'h00FF}) begin
            errors++;
            $display("FAIL xbus_read: got ack_b=%b rdata_b=%h rdata_a=%h, expected 1 a5a5 00ff", ack_b, rdata_b, rdata_a);
        end
        idle_inputs();
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if ($isunknown({rdata_a, rdata_b}) || {rdata_a, rdata_b} !== {16'h00FF, 16'hA5A5}) begin
                errors++;
                $display("FAIL xbus_hold cycle %0d: got rdata_a=%h rdata_b=%h, expected 00ff a5a5", k, rdata_a, rdata_b);
            end
        end
        dout_x_mode = 0;
    endtask

    initial begin
        rst = 1;
        idle_inputs();
        test_reset();
        test_write_read_a();
        test_tie_from_reset();
        test_back_to_back();
        test_reset_during_write();
        test_dout_x();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
